// File: rtl/posit_defines_es3.sv
// Shared constants for the ES3 accumulator-to-posit16 conversion path.
// Contains no ports; it supplies default geometry and the posit<16,3> special encodings.
package posit_defines_es3;

    localparam int unsigned POSIT16_ES3_NBITS   = 16;
    localparam int unsigned POSIT16_ES3_ES      = 3;
    localparam int unsigned POSIT16_ES3_SCALE_W = 10;
    // Fraction width of the accumulator's serialized raw value (hidden bit excluded).
    localparam int unsigned FBITS_ACCUM         = 32;

    // Largest and smallest scale representable without saturating.
    localparam int POSIT16_ES3_MAXSCALE = 111;
    localparam int POSIT16_ES3_MINSCALE = -112;

    localparam logic [15:0] POSIT16_NAR    = 16'h8000;
    localparam logic [15:0] POSIT16_MAXPOS = 16'h7FFF;
    localparam logic [15:0] POSIT16_MINPOS = 16'h0001;

endpackage

// File: rtl/posit_regime_encode.sv
// Combinational posit regime encoder.
// Ports:
//   k_i       in  K_W     regime value k, two's complement
//   regime_o  out NBITS   regime bit pattern, MSB-aligned, zero below it
//   len_o     out RLEN_W  regime length including the terminating bit
// k >= 0 gives k+1 ones then a 0; k < 0 gives -k zeros then a 1. The run is clamped to
// NBITS-1 so out-of-range k (which the top overrides with saturation) stays well-formed.
module posit_regime_encode #(
    parameter int unsigned NBITS  = 16,
    parameter int unsigned K_W    = 7,
    parameter int unsigned RLEN_W = 5
) (
    input  logic [K_W-1:0]    k_i,
    output logic [NBITS-1:0]  regime_o,
    output logic [RLEN_W-1:0] len_o
);

    localparam logic [K_W-1:0] RUN_MAX = K_W'(NBITS - 1);

    logic              neg;
    logic [K_W-1:0]    run_raw;
    logic [RLEN_W-1:0] run;

    always_comb begin
        neg     = k_i[K_W-1];
        // Unsigned magnitude: -k for negative k, k+1 otherwise.
        run_raw = neg ? (~k_i + K_W'(1)) : (k_i + K_W'(1));
        run     = (run_raw > RUN_MAX) ? RLEN_W'(NBITS - 1) : RLEN_W'(run_raw);
        len_o   = run + RLEN_W'(1);
        if (neg) begin
            regime_o = {1'b1, {(NBITS-1){1'b0}}} >> run;
        end else begin
            regime_o = ~({NBITS{1'b1}} >> run);
        end
    end

endmodule

// File: rtl/shift_right.sv
// Logical right shifter, zero fill.
// Ports:
//   data_i   in  WIDTH  value to shift
//   shamt_i  in  SHW    shift amount
//   data_o   out WIDTH  data_i >> shamt_i
module shift_right #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = data_i >> shamt_i;

endmodule

// File: rtl/posit_accum_to_posit16_es3.sv
// Converts the ES3 accumulator's raw result into a posit<NBITS,ES> word, rounding to
// nearest-even with the upstream truncation flag folded into sticky. 3-stage pipeline:
// S1 decode/saturation detect, S2 regime build and body alignment, S3 round and specials.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_raw        {sgn, scale, fraction (MSB-first), inf, zero}
//   in_valid      in_raw valid this cycle
//   in_truncated  low bits lost upstream, ORed into sticky
//   out_posit     converted posit, two's complement; holds while out_valid=0
//   out_valid     out_posit valid this cycle
//   out_inexact   guard|sticky nonzero, or saturated
module posit_accum_to_posit16_es3
    import posit_defines_es3::*;
#(
    parameter int unsigned NBITS   = POSIT16_ES3_NBITS,
    parameter int unsigned ES      = POSIT16_ES3_ES,
    parameter int unsigned SCALE_W = POSIT16_ES3_SCALE_W,
    parameter int unsigned FRAC_W  = FBITS_ACCUM
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SCALE_W+FRAC_W+2:0] in_raw,
    input  logic                      in_valid,
    input  logic                      in_truncated,
    output logic [NBITS-1:0]          out_posit,
    output logic                      out_valid,
    output logic                      out_inexact
);

    localparam int unsigned K_W    = SCALE_W - ES;
    localparam int unsigned BODY_W = NBITS + ES + FRAC_W;
    localparam int unsigned RLEN_W = $clog2(NBITS + 1);
    localparam int          MAX_SCALE = int'((NBITS - 2) << ES) - 1;
    localparam int          MIN_SCALE = -int'((NBITS - 2) << ES);
    localparam logic signed [SCALE_W-1:0] SCALE_HI = SCALE_W'(MAX_SCALE);
    localparam logic signed [SCALE_W-1:0] SCALE_LO = SCALE_W'(MIN_SCALE);
    localparam logic [NBITS-1:0] NAR    = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-1:0] MAXPOS = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic [NBITS-1:0] MINPOS = NBITS'(1);

    typedef struct packed {
        logic              sgn;
        logic [K_W-1:0]    k;
        logic [ES-1:0]     e;
        logic [FRAC_W-1:0] frac;
        logic              inf;
        logic              zero;
        logic              sat_hi;
        logic              sat_lo;
        logic              trunc;
    } s1_t;

    typedef struct packed {
        logic             sgn;
        logic [NBITS-2:0] mag;
        logic             guard;
        logic             sticky;
        logic             inf;
        logic             zero;
        logic             sat_hi;
        logic             sat_lo;
    } s2_t;

    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;
    logic             s1_valid_q, s2_valid_q;
    logic [NBITS-1:0] out_posit_d, out_posit_q;
    logic             out_inexact_d, out_inexact_q, out_valid_q;

    // S1: decode scale into k/e and flag out-of-range scales.
    logic signed [SCALE_W-1:0] in_scale;
    assign in_scale = in_raw[FRAC_W+2 +: SCALE_W];

    always_comb begin
        s1_d = s1_q;
        if (in_valid) begin
            s1_d.sgn    = in_raw[SCALE_W+FRAC_W+2];
            s1_d.k      = in_scale[SCALE_W-1:ES];  // scale >>> ES
            s1_d.e      = in_scale[ES-1:0];
            s1_d.frac   = in_raw[2 +: FRAC_W];
            s1_d.inf    = in_raw[1];
            s1_d.zero   = in_raw[0];
            s1_d.sat_hi = in_scale > SCALE_HI;
            s1_d.sat_lo = in_scale < SCALE_LO;
            s1_d.trunc  = in_truncated;
        end
    end

    // S2: body = {regime, e, fraction}; {e, fraction} is shifted down under the regime.
    // NBITS zero pad at the bottom means the shift never drops a bit before sticky.
    logic [NBITS-1:0]  regime;
    logic [RLEN_W-1:0] regime_len;
    logic [BODY_W-1:0] ef, ef_sh, body;

    posit_regime_encode #(
        .NBITS  (NBITS),
        .K_W    (K_W),
        .RLEN_W (RLEN_W)
    ) u_regime (
        .k_i      (s1_q.k),
        .regime_o (regime),
        .len_o    (regime_len)
    );

    assign ef = {s1_q.e, s1_q.frac, {NBITS{1'b0}}};

    shift_right #(
        .WIDTH (BODY_W),
        .SHW   (RLEN_W)
    ) u_align (
        .data_i  (ef),
        .shamt_i (regime_len),
        .data_o  (ef_sh)
    );

    assign body = {regime, {(BODY_W-NBITS){1'b0}}} | ef_sh;

    always_comb begin
        s2_d = s2_q;
        if (s1_valid_q) begin
            s2_d.sgn    = s1_q.sgn;
            s2_d.mag    = body[BODY_W-1 -: NBITS-1];
            s2_d.guard  = body[BODY_W-NBITS];
            s2_d.sticky = (|body[BODY_W-NBITS-1:0]) | s1_q.trunc;
            s2_d.inf    = s1_q.inf;
            s2_d.zero   = s1_q.zero;
            s2_d.sat_hi = s1_q.sat_hi;
            s2_d.sat_lo = s1_q.sat_lo;
        end
    end

    // S3: round to nearest even, clamp into [minpos, maxpos], apply sign and specials.
    logic             inc;
    logic [NBITS-1:0] sum, word;
    logic [NBITS-2:0] rnd_mag;

    always_comb begin
        inc     = s2_q.guard & (s2_q.sticky | s2_q.mag[0]);
        sum     = {1'b0, s2_q.mag} + NBITS'(inc);
        rnd_mag = sum[NBITS-1] ? '1 : sum[NBITS-2:0];
        if (rnd_mag == '0) begin
            rnd_mag = (NBITS-1)'(1);
        end
        word = {1'b0, rnd_mag};

        out_posit_d   = out_posit_q;
        out_inexact_d = out_inexact_q;
        if (s2_valid_q) begin
            if (s2_q.inf) begin
                out_posit_d   = NAR;
                out_inexact_d = 1'b0;
            end else if (s2_q.zero) begin
                out_posit_d   = '0;
                out_inexact_d = 1'b0;
            end else if (s2_q.sat_hi) begin
                out_posit_d   = s2_q.sgn ? -MAXPOS : MAXPOS;
                out_inexact_d = 1'b1;
            end else if (s2_q.sat_lo) begin
                out_posit_d   = s2_q.sgn ? -MINPOS : MINPOS;
                out_inexact_d = 1'b1;
            end else begin
                out_posit_d   = s2_q.sgn ? -word : word;
                out_inexact_d = s2_q.guard | s2_q.sticky;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
            out_posit_q   <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            s1_valid_q    <= in_valid;
            s2_valid_q    <= s1_valid_q;
            out_valid_q   <= s2_valid_q;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            out_posit_q   <= out_posit_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign out_posit   = out_posit_q;
    assign out_valid   = out_valid_q;
    assign out_inexact = out_inexact_q;

endmodule
